// File: rtl/adc_spi_responder.sv
// adc_spi_responder
//
// Stands in for one dual-ADC serial front end so the SPI ADC read controller
// can be tested without the real chips. One instance serves one chip select.
// A rising CONVST starts a conversion: the sample frame is captured and BUSY
// stays high for BUSY_CYCLES clocks. After that, while CS is low, the frame is
// shifted out on DOUTA, MSB first, changing on SCLK falling edges.
//
// Ports:
//   i_Clk          fabric clock, also used to oversample SCLK
//   i_Reset        asynchronous, active-high reset
//   i_CONVST       conversion start; idles high, acts on its rising edge
//   i_CS_n         chip select, active low
//   i_SCLK         serial clock from the controller, idles low
//   i_Sample_Data  frame contents, captured at conversion start
//   i_Test_Mode    (only with ADC_SPI_RESPONDER_TEST_PATTERN_EN) send a
//                  generated pattern frame instead of i_Sample_Data
//   o_BUSY         high while converting
//   o_DOUTA        serial data out, 0 whenever CS is high
//   o_Frame_Done   one-cycle pulse after a complete frame was read
//   o_Short_Read   sticky: CS rose before the whole frame was clocked out
//   o_Conv_Err     sticky: CONVST rose while converting or shifting
//
// Optional feature macro: ADC_SPI_RESPONDER_TEST_PATTERN_EN. When defined,
// the i_Test_Mode port and an 8-bit capture counter are added; channel k of
// the generated frame is {frame_cnt, 5'b0, k}, channel 0 in the top 16 bits.

module adc_spi_responder #(
  parameter int FRAME_BITS  = 128,
  parameter int BUSY_CYCLES = 200,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_CONVST,
  input  logic                  i_CS_n,
  input  logic                  i_SCLK,
`ifdef ADC_SPI_RESPONDER_TEST_PATTERN_EN
  input  logic                  i_Test_Mode,
`endif
  input  logic [FRAME_BITS-1:0] i_Sample_Data,
  output logic                  o_BUSY,
  output logic                  o_DOUTA,
  output logic                  o_Frame_Done,
  output logic                  o_Short_Read,
  output logic                  o_Conv_Err
);

  localparam int BUSY_W = $clog2(BUSY_CYCLES + 1);
  localparam int BIT_W  = $clog2(FRAME_BITS + 1);
  localparam logic [BUSY_W-1:0] BUSY_LOAD  = BUSY_W'(BUSY_CYCLES - 1);
  localparam logic [BIT_W-1:0]  FULL_COUNT = BIT_W'(FRAME_BITS);

  typedef enum logic [1:0] {IDLE, CONVERTING, READY, SHIFTING} state_t;

  logic [SYNC_STAGES-1:0] convst_sync, cs_sync, sclk_sync;
  logic                   convst_prev, cs_prev, sclk_prev;
  logic [FRAME_BITS-1:0]  data_pipe [SYNC_STAGES];

  logic convst_s, cs_s, sclk_s;
  logic convst_rise, cs_fall, cs_rise, sclk_rise, sclk_fall;

  state_t                state, state_nxt;
  logic [BUSY_W-1:0]     busy_cnt, busy_cnt_nxt;
  logic [BIT_W-1:0]      bit_cnt, bit_cnt_nxt;
  logic [FRAME_BITS-1:0] conv_reg, conv_reg_nxt;
  logic [FRAME_BITS-1:0] shreg, shreg_nxt;
  logic [FRAME_BITS-1:0] capture_value;
  logic busy_q, busy_nxt, douta_q, douta_nxt, done_q, done_nxt;
  logic short_q, short_nxt, err_q, err_nxt;

`ifdef ADC_SPI_RESPONDER_TEST_PATTERN_EN
  logic [SYNC_STAGES-1:0] test_pipe;
  logic [7:0]             frame_cnt, frame_cnt_nxt;

  function automatic logic [FRAME_BITS-1:0] make_pattern(input logic [7:0] cnt);
    logic [FRAME_BITS-1:0] f;
    f = '0;
    for (int k = 0; k < FRAME_BITS / 16; k++) begin
      f[FRAME_BITS-1-16*k -: 16] = {cnt, 5'b0, 3'(k)};
    end
    return f;
  endfunction
`endif

  // Control inputs go through SYNC_STAGES flops plus one extra copy for edge
  // detection. The sample data (and test mode) are delayed by the same number
  // of stages so that the value captured is the one present at the CONVST pin
  // edge, not the one present when the synchronized edge finally arrives.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      convst_sync <= '1;
      cs_sync     <= '1;
      sclk_sync   <= '0;
      convst_prev <= 1'b1;
      cs_prev     <= 1'b1;
      sclk_prev   <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) data_pipe[i] <= '0;
`ifdef ADC_SPI_RESPONDER_TEST_PATTERN_EN
      test_pipe   <= '0;
`endif
    end else begin
      convst_sync <= {convst_sync[SYNC_STAGES-2:0], i_CONVST};
      cs_sync     <= {cs_sync[SYNC_STAGES-2:0], i_CS_n};
      sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], i_SCLK};
      convst_prev <= convst_s;
      cs_prev     <= cs_s;
      sclk_prev   <= sclk_s;
      data_pipe[0] <= i_Sample_Data;
      for (int i = 1; i < SYNC_STAGES; i++) data_pipe[i] <= data_pipe[i-1];
`ifdef ADC_SPI_RESPONDER_TEST_PATTERN_EN
      test_pipe   <= {test_pipe[SYNC_STAGES-2:0], i_Test_Mode};
`endif
    end
  end

  assign convst_s    = convst_sync[SYNC_STAGES-1];
  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign convst_rise = convst_s & ~convst_prev;
  assign cs_fall     = ~cs_s & cs_prev;
  assign cs_rise     = cs_s & ~cs_prev;
  assign sclk_rise   = sclk_s & ~sclk_prev;
  assign sclk_fall   = ~sclk_s & sclk_prev;

`ifdef ADC_SPI_RESPONDER_TEST_PATTERN_EN
  assign capture_value = test_pipe[SYNC_STAGES-1] ? make_pattern(frame_cnt)
                                                  : data_pipe[SYNC_STAGES-1];
`else
  assign capture_value = data_pipe[SYNC_STAGES-1];
`endif

  // State and datapath registers.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state    <= IDLE;
      busy_cnt <= '0;
      bit_cnt  <= '0;
      conv_reg <= '0;
      shreg    <= '0;
      busy_q   <= 1'b0;
      douta_q  <= 1'b0;
      done_q   <= 1'b0;
      short_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef ADC_SPI_RESPONDER_TEST_PATTERN_EN
      frame_cnt <= '0;
`endif
    end else begin
      state    <= state_nxt;
      busy_cnt <= busy_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      conv_reg <= conv_reg_nxt;
      shreg    <= shreg_nxt;
      busy_q   <= busy_nxt;
      douta_q  <= douta_nxt;
      done_q   <= done_nxt;
      short_q  <= short_nxt;
      err_q    <= err_nxt;
`ifdef ADC_SPI_RESPONDER_TEST_PATTERN_EN
      frame_cnt <= frame_cnt_nxt;
`endif
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_nxt    = state;
    busy_cnt_nxt = busy_cnt;
    bit_cnt_nxt  = bit_cnt;
    conv_reg_nxt = conv_reg;
    shreg_nxt    = shreg;
    busy_nxt     = busy_q;
    douta_nxt    = douta_q;
    done_nxt     = 1'b0;
    short_nxt    = short_q;
    err_nxt      = err_q;
`ifdef ADC_SPI_RESPONDER_TEST_PATTERN_EN
    frame_cnt_nxt = frame_cnt;
`endif

    unique case (state)
      IDLE, READY: begin
        // A new conversion from READY silently drops the unread frame.
        if (convst_rise) begin
          conv_reg_nxt = capture_value;
          busy_cnt_nxt = BUSY_LOAD;
          busy_nxt     = 1'b1;
          state_nxt    = CONVERTING;
`ifdef ADC_SPI_RESPONDER_TEST_PATTERN_EN
          frame_cnt_nxt = frame_cnt + 8'd1;
`endif
        end else if (state == READY && cs_fall) begin
          douta_nxt   = shreg[FRAME_BITS-1];
          bit_cnt_nxt = '0;
          state_nxt   = SHIFTING;
        end
      end

      CONVERTING: begin
        if (convst_rise) err_nxt = 1'b1;
        if (busy_cnt == '0) begin
          busy_nxt  = 1'b0;
          shreg_nxt = conv_reg;
          state_nxt = READY;
        end else begin
          busy_cnt_nxt = busy_cnt - 1'b1;
        end
      end

      SHIFTING: begin
        if (convst_rise) err_nxt = 1'b1;
        // CS release wins over a coincident SCLK edge.
        if (cs_rise) begin
          if (bit_cnt == FULL_COUNT) done_nxt = 1'b1;
          else                       short_nxt = 1'b1;
          douta_nxt = 1'b0;
          state_nxt = IDLE;
        end else begin
          // Completion is judged on the controller's sampling (rising) edges,
          // so a CS release right after the last rising edge is still a full
          // frame. Data moves on falling edges; zeros fill in from the bottom,
          // which leaves DOUTA low once the frame is exhausted.
          if (sclk_rise && bit_cnt != FULL_COUNT) bit_cnt_nxt = bit_cnt + 1'b1;
          if (sclk_fall) begin
            shreg_nxt = shreg << 1;
            douta_nxt = shreg[FRAME_BITS-2];
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign o_BUSY       = busy_q;
  assign o_DOUTA      = douta_q & ~cs_s;
  assign o_Frame_Done = done_q;
  assign o_Short_Read = short_q;
  assign o_Conv_Err   = err_q;

endmodule
